room_occupancy_ctrl: RTL and testbench

//   Multi-door occupancy controller for the room access system.

---
 rtl/room_occupancy_ctrl.sv | 118 +++++++++++
 tb/tb_room_occupancy_ctrl.sv | 115 +++++++++++
 2 files changed

// File: rtl/room_occupancy_ctrl.sv
// Multi-door room occupancy controller: arbitrates per-door entry/exit requests
// against CAPACITY. Optional sticky phantom-exit flag under macro ROOM_ERR_EN.
module room_occupancy_ctrl #(
  parameter int N_DOORS  = 2,
  parameter int CAPACITY = 15,
  parameter int CNT_W    = 4
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               T,
  input  logic [N_DOORS-1:0] in,
  input  logic [N_DOORS-1:0] ent,
  input  logic [N_DOORS-1:0] out,
  output logic [N_DOORS-1:0] open,
  output logic [N_DOORS-1:0] deny,
  output logic               close,
  output logic               full,
  output logic [CNT_W-1:0]   count,
  output logic               err,
  output logic [1:0]         o_dbg_state
);

  localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_count;
  logic [N_DOORS-1:0] r_open;
  logic [N_DOORS-1:0] r_deny;
  logic               r_close;
  logic               r_full;

  logic [N_DOORS-1:0] w_ereq;
  logic [N_DOORS-1:0] w_xreq;
  logic [N_DOORS-1:0] w_open;
  logic [N_DOORS-1:0] w_deny;
  logic               w_phantom;
  logic [CNT_W-1:0]   w_occ;
  state_t             w_next_state;

  assign w_ereq = in & ent & ~out;
  assign w_xreq = out & ~(in & ent);

  // w_occ is the running occupancy: exits are applied first so that slots they
  // free can be taken by entries in the same cycle.
  always_comb begin
    w_open    = '0;
    w_deny    = '0;
    w_phantom = 1'b0;
    w_occ     = r_count;
    for (int i = 0; i < N_DOORS; i++) begin
      if (w_xreq[i]) begin
        if (w_occ != '0) w_occ = w_occ - 1'b1;
        else             w_phantom = 1'b1;
      end
    end
    for (int i = 0; i < N_DOORS; i++) begin
      if (w_ereq[i]) begin
        if (T && (w_occ < CAP)) begin
          w_occ     = w_occ + 1'b1;
          w_open[i] = 1'b1;
        end else begin
          w_deny[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    if (w_occ == '0)       w_next_state = EMPTY;
    else if (w_occ == CAP) w_next_state = FULL;
    else                   w_next_state = PARTIAL;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= EMPTY;
      r_count <= '0;
      r_open  <= '0;
      r_deny  <= '0;
      r_close <= 1'b1;
      r_full  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_count <= w_occ;
      r_open  <= w_open;
      r_deny  <= w_deny;
      r_close <= (w_next_state == EMPTY);
      r_full  <= (w_next_state == FULL);
    end
  end

`ifdef ROOM_ERR_EN
  logic r_err;
  always_ff @(posedge clk) begin
    if (clr)            r_err <= 1'b0;
    else if (w_phantom) r_err <= 1'b1;
  end
  assign err = r_err;
`else
  logic w_unused_phantom;
  assign w_unused_phantom = w_phantom;
  assign err = 1'b0;
`endif

  assign open        = r_open;
  assign deny        = r_deny;
  assign close       = r_close;
  assign full        = r_full;
  assign count       = r_count;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_room_occupancy_ctrl.sv
// Directed table-driven bench for room_occupancy_ctrl (N_DOORS=2, CAPACITY=15).
module tb_room_occupancy_ctrl;

`ifdef ROOM_ERR_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  logic       clk;
  logic       clr;
  logic       t_en;
  logic [1:0] s_in, s_ent, s_out;
  logic [1:0] open, deny;
  logic       close, full, err;
  logic [3:0] count;
  logic [1:0] dbg_state;

  room_occupancy_ctrl #(.N_DOORS(2), .CAPACITY(15), .CNT_W(4)) dut (
    .clk(clk), .clr(clr), .T(t_en), .in(s_in), .ent(s_ent), .out(s_out),
    .open(open), .deny(deny), .close(close), .full(full), .count(count),
    .err(err), .o_dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       clr;
    logic       t;
    logic [1:0] in;
    logic [1:0] ent;
    logic [1:0] out;
    logic [1:0] e_open;
    logic [1:0] e_deny;
    logic [3:0] e_count;
    logic       e_close;
    logic       e_full;
    logic       e_err;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic add(input string nm, input logic c, input logic t,
                     input logic [1:0] i, input logic [1:0] e, input logic [1:0] o,
                     input logic [1:0] eo, input logic [1:0] ed, input logic [3:0] ec,
                     input logic ecl, input logic ef, input logic ee);
    vec_t v;
    v.name = nm; v.clr = c; v.t = t; v.in = i; v.ent = e; v.out = o;
    v.e_open = eo; v.e_deny = ed; v.e_count = ec;
    v.e_close = ecl; v.e_full = ef; v.e_err = ee;
    vecs.push_back(v);
  endtask

  // Drive on the falling edge, let one rising edge register, check on the next falling edge.
  task automatic apply(input vec_t v);
    clr = v.clr; t_en = v.t; s_in = v.in; s_ent = v.ent; s_out = v.out;
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (open !== v.e_open || deny !== v.e_deny || count !== v.e_count ||
        close !== v.e_close || full !== v.e_full || err !== v.e_err) begin
      n_fail++;
      $display("FAIL %s: got open=%b deny=%b count=%0d close=%b full=%b err=%b, want open=%b deny=%b count=%0d close=%b full=%b err=%b",
               v.name, open, deny, count, close, full, err,
               v.e_open, v.e_deny, v.e_count, v.e_close, v.e_full, v.e_err);
    end
  endtask

  initial begin
    clr = 1'b1; t_en = 1'b0; s_in = '0; s_ent = '0; s_out = '0;
    //   name            clr T  in     ent    out    open   deny   cnt  cls  ful  err
    add("reset",         1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0,   1,   0,   0);
    add("idle",          0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0,   1,   0,   0);
    add("enter2",        0, 1, 2'b11, 2'b11, 2'b00, 2'b11, 2'b00, 2,   0,   0,   0);
    add("pulse_low",     0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2,   0,   0,   0);
    add("t_off_deny",    0, 0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2,   0,   0,   0);
    add("same_door",     0, 1, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2,   0,   0,   0);
    add("no_badge",      0, 1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2,   0,   0,   0);
    for (int k = 0; k < 6; k++)
      add("fill",        0, 1, 2'b11, 2'b11, 2'b00, 2'b11, 2'b00, 4'(4 + 2*k), 0, 0, 0);
    add("cap_edge",      0, 1, 2'b11, 2'b11, 2'b00, 2'b01, 2'b10, 15,  0,   1,   0);
    add("swap_at_full",  0, 1, 2'b10, 2'b10, 2'b01, 2'b10, 2'b00, 15,  0,   1,   0);
    add("full_deny",     0, 1, 2'b11, 2'b11, 2'b00, 2'b00, 2'b11, 15,  0,   1,   0);
    add("exit2",         0, 1, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 13,  0,   0,   0);
    add("clr_mid_burst", 1, 1, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 0,   1,   0,   0);
    add("enter1",        0, 1, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00, 1,   0,   0,   0);
    add("phantom",       0, 0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 0,   1,   0,   ERR_ON);
    add("err_hold",      0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0,   1,   0,   ERR_ON);
    add("exit_empty",    0, 0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 0,   1,   0,   ERR_ON);
    add("exit_frees",    0, 1, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00, 1,   0,   0,   ERR_ON);
    add("xchg_door",     0, 1, 2'b01, 2'b01, 2'b10, 2'b01, 2'b00, 1,   0,   0,   ERR_ON);
    add("err_clr",       1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0,   1,   0,   0);

    @(negedge clk);
    foreach (vecs[i]) apply(vecs[i]);

    // Held request is re-evaluated every cycle, then pulses drop once released.
    vecs.delete();
    add("h_reset",       1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0,   1,   0,   0);
    for (int k = 1; k <= 3; k++)
      add("held_entry",  0, 1, 2'b10, 2'b10, 2'b00, 2'b10, 2'b00, 4'(k), 0, 0, 0);
    add("held_release",  0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3,   0,   0,   0);
    for (int k = 2; k >= 0; k--)
      add("held_exit",   0, 0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 4'(k), (k == 0), 0, 0);
    foreach (vecs[i]) apply(vecs[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
